// File: rtl/log_motion_pkg.sv
// Shared constants, lane speed table and FSM state type for the river-log motion block.
package log_motion_pkg;

  localparam int NUM_LANES     = 5;
  localparam int LOGS_PER_LANE = 3;
  localparam int NUM_OF_LOGS   = NUM_LANES * LOGS_PER_LANE;
  localparam int SCREEN_W      = 640;
  localparam int LOG_W         = 40;
  localparam int WRAP_W        = SCREEN_W + LOG_W;
  localparam int LANE_Y0       = 80;
  localparam int LANE_PITCH    = 32;
  localparam int LANE_STAGGER  = 48;
  localparam int FRAC_BITS     = 4;
  localparam int POS_W         = 11 + FRAC_BITS;
  localparam int WRAPQ         = WRAP_W << FRAC_BITS;

  // Base speed per lane in 1/16 pixel per frame.
  localparam logic [7:0] BASE_SPEED [NUM_LANES] = '{8'd16, 8'd24, 8'd12, 8'd20, 8'd32};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [2:0] lane_of(input logic [3:0] idx);
    return 3'(idx / 4'(LOGS_PER_LANE));
  endfunction

  function automatic logic [POS_W-1:0] init_pos(input int i);
    int x;
    x = (i % LOGS_PER_LANE) * (WRAP_W / LOGS_PER_LANE) + (i / LOGS_PER_LANE) * LANE_STAGGER;
    return POS_W'(x << FRAC_BITS);
  endfunction

endpackage

// File: rtl/log_motion_ctrl_log_step_unit.sv
// Combinational wrap-around add/subtract of one position accumulator by one step.
import log_motion_pkg::*;

module log_step_unit (
  input  logic [POS_W-1:0] pos,
  input  logic [8:0]       step,
  input  logic             dir_left,
  output logic [POS_W-1:0] pos_next
);

  logic [POS_W:0] sum;
  logic [POS_W:0] wrap_q;

  assign wrap_q = (POS_W+1)'(WRAPQ);

  always_comb begin
    sum = '0;
    if (dir_left) begin
      if ({1'b0, pos} < (POS_W+1)'(step))
        sum = {1'b0, pos} + wrap_q - (POS_W+1)'(step);
      else
        sum = {1'b0, pos} - (POS_W+1)'(step);
    end else begin
      sum = {1'b0, pos} + (POS_W+1)'(step);
      if (sum >= wrap_q)
        sum = sum - wrap_q;
    end
    pos_next = sum[POS_W-1:0];
  end

endmodule

// File: rtl/log_motion_ctrl.sv
// River-log position owner: one shared step unit swept over all logs once per frame.
import log_motion_pkg::*;

module log_motion_ctrl (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        restart,
  input  logic [2:0]  level,
  output logic [10:0] ObjectStartX [NUM_OF_LOGS],
  output logic [10:0] ObjectStartY [NUM_OF_LOGS],
  output logic        busy,
  output logic        update_done,
  output logic        frame_overrun,
  output logic [1:0]  state_dbg
);

  state_t            state, state_next;
  logic [3:0]        idx;
  logic [2:0]        lvl;
  logic [POS_W-1:0]  pos [NUM_OF_LOGS];
  logic [2:0]        lane;
  logic [8:0]        step;
  logic [POS_W-1:0]  step_next;
  logic              load_all;
  logic              frame_req;
  logic              late_frame;

  // Nine bits so lane 4 at level 7 (32*8 = 256) does not alias to zero.
  assign lane       = lane_of(idx);
  assign step       = 9'(BASE_SPEED[lane]) * (9'(lvl) + 9'd1);
  assign frame_req  = startOfFrame && enable && !restart;
  assign late_frame = frame_req && (state == S_STEP || state == S_DONE);
  assign load_all   = (state_next == S_LOAD);

  log_step_unit u_step (
    .pos      (pos[idx]),
    .step     (step),
    .dir_left (lane[0]),
    .pos_next (step_next)
  );

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = S_LOAD;
    end else begin
      case (state)
        S_IDLE:  if (startOfFrame && enable) state_next = S_STEP;
        S_LOAD:  state_next = S_IDLE;
        S_STEP:  if (idx == 4'(NUM_OF_LOGS-1)) state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state         <= S_IDLE;
      idx           <= '0;
      lvl           <= '0;
      frame_overrun <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && state_next == S_STEP) begin
        idx <= '0;
        lvl <= level;
      end else if (state == S_STEP) begin
        idx <= idx + 4'd1;
      end
      if (load_all)
        frame_overrun <= 1'b0;
      else if (late_frame)
        frame_overrun <= 1'b1;
    end
  end

  // Restart reloads on the edge that enters LOAD, overwriting any partial sweep.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NUM_OF_LOGS; i++)
        pos[i] <= init_pos(i);
    end else begin
      for (int i = 0; i < NUM_OF_LOGS; i++) begin
        if (load_all)
          pos[i] <= init_pos(i);
        else if (state == S_STEP && idx == 4'(i))
          pos[i] <= step_next;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_OF_LOGS; g++) begin : g_out
      assign ObjectStartX[g] = pos[g][POS_W-1:FRAC_BITS];
      assign ObjectStartY[g] = 11'(LANE_Y0 + (g / LOGS_PER_LANE) * LANE_PITCH);
    end
  endgenerate

  assign busy        = (state != S_IDLE);
  assign update_done = (state == S_DONE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_log_motion_ctrl.sv
// Bench for log_motion_ctrl: per-cycle comparison against a frame-level position model.
module tb_log_motion_ctrl;

  localparam int N     = 15;
  localparam int WRAPQ = 680 * 16;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic [2:0]  level = 3'd0;
  logic [10:0] ObjectStartX [N];
  logic [10:0] ObjectStartY [N];
  logic        busy, update_done, frame_overrun;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  log_motion_ctrl dut (
    .CLK(CLK), .RESETn(RESETn), .startOfFrame(startOfFrame), .enable(enable),
    .restart(restart), .level(level), .ObjectStartX(ObjectStartX),
    .ObjectStartY(ObjectStartY), .busy(busy), .update_done(update_done),
    .frame_overrun(frame_overrun), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  int base_speed [5] = '{16, 24, 12, 20, 32};
  int m_pos [N];
  int m_sweep;     // -1 idle, 0..14 next log to move, 15 completion cycle
  bit m_load;
  int m_lvl;
  bit m_ovr;

  function automatic int init_p(int i);
    return ((i % 3) * 226 + (i / 3) * 48) * 16;
  endfunction

  function automatic int moved(int p, int i, int lv);
    int s;
    s = base_speed[i / 3] * (lv + 1);
    if ((i / 3) % 2 == 1) return (p - s + WRAPQ) % WRAPQ;
    return (p + s) % WRAPQ;
  endfunction

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < N; i++) m_pos[i] = init_p(i);
      m_sweep = -1; m_load = 0; m_ovr = 0; m_lvl = 0;
    end else if (restart) begin
      for (int i = 0; i < N; i++) m_pos[i] = init_p(i);
      m_sweep = -1; m_load = 1; m_ovr = 0;
    end else if (m_load) begin
      m_load = 0;
    end else if (m_sweep < 0) begin
      if (startOfFrame && enable) begin
        m_sweep = 0; m_lvl = int'(level);
      end
    end else begin
      if (startOfFrame && enable) m_ovr = 1;
      if (m_sweep < N) begin
        m_pos[m_sweep] = moved(m_pos[m_sweep], m_sweep, m_lvl);
        m_sweep++;
      end else begin
        m_sweep = -1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    if (chk_on) begin
      int bad;
      bad = -1;
      for (int i = 0; i < N; i++)
        if (bad < 0 && (int'(ObjectStartX[i]) != m_pos[i] / 16 ||
                        int'(ObjectStartY[i]) != 80 + (i / 3) * 32)) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL model_xy log%0d: got X=%0d Y=%0d, want X=%0d Y=%0d t=%0t",
                 bad, ObjectStartX[bad], ObjectStartY[bad], m_pos[bad] / 16, 80 + (bad / 3) * 32, $time);
      end
      checks++;
      if (busy !== (m_load || m_sweep >= 0) || update_done !== (m_sweep == N) || frame_overrun !== m_ovr) begin
        errors++;
        $display("FAIL model_flags: got busy=%b done=%b ovr=%b, want busy=%b done=%b ovr=%b t=%0t",
                 busy, update_done, frame_overrun, (m_load || m_sweep >= 0), (m_sweep == N), m_ovr, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic pulse_restart();
    @(negedge CLK); restart = 1'b1;
    @(negedge CLK); restart = 1'b0;
    @(negedge CLK);
  endtask

  // Fires one frame and waits for the sweep to end; returns busy and done counts.
  task automatic frame(input int lv, output int nb, output int nd);
    @(negedge CLK); startOfFrame = 1'b1; enable = 1'b1; level = 3'(lv);
    @(negedge CLK); startOfFrame = 1'b0;
    nb = 0; nd = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      nb++;
      if (update_done) nd++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int nb, nd;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    chk_on = 1;
    @(negedge CLK);
    chk("rst_x0", ObjectStartX[0], 0);
    chk("rst_y0", ObjectStartY[0], 80);
    chk("rst_x3", ObjectStartX[3], 48);
    chk("rst_y3", ObjectStartY[3], 112);
    chk("rst_x14", ObjectStartX[14], 644);
    chk("rst_y14", ObjectStartY[14], 208);
    chk("rst_busy", busy, 0);

    frame(0, nb, nd);
    chk("sweep_busy_cycles", nb, 16);
    chk("sweep_done_pulses", nd, 1);
    chk("f1_x0", ObjectStartX[0], 1);
    chk("f1_x3", ObjectStartX[3], 46);
    chk("f1_x1", ObjectStartX[1], 227);

    for (int f = 1; f < 32; f++) frame(0, nb, nd);
    chk("f32_x3", ObjectStartX[3], 0);
    frame(0, nb, nd);
    chk("f33_x3", ObjectStartX[3], 678);
    frame(0, nb, nd);
    chk("f34_x3", ObjectStartX[3], 677);

    pulse_restart();
    chk("restart_x3", ObjectStartX[3], 48);
    frame(3, nb, nd);
    chk("lvl3_x0", ObjectStartX[0], 4);
    chk("lvl3_x12", ObjectStartX[12], 200);

    // Second frame pulse five cycles into a sweep.
    pulse_restart();
    @(negedge CLK); startOfFrame = 1'b1; enable = 1'b1; level = 3'd0;
    @(negedge CLK); startOfFrame = 1'b0;
    repeat (4) @(negedge CLK);
    startOfFrame = 1'b1;
    @(negedge CLK); startOfFrame = 1'b0;
    for (int k = 0; k < 40 && busy; k++) @(negedge CLK);
    chk("ovr_set", frame_overrun, 1);
    chk("ovr_x0_one_step", ObjectStartX[0], 1);
    chk("ovr_x3_one_step", ObjectStartX[3], 46);
    pulse_restart();
    chk("ovr_cleared", frame_overrun, 0);
    chk("ovr_restart_x0", ObjectStartX[0], 0);

    // Restart together with a frame pulse seven cycles into a sweep.
    @(negedge CLK); startOfFrame = 1'b1;
    @(negedge CLK); startOfFrame = 1'b0;
    repeat (6) @(negedge CLK);
    restart = 1'b1; startOfFrame = 1'b1;
    @(negedge CLK); restart = 1'b0; startOfFrame = 1'b0;
    chk("abort_busy_load", busy, 1);
    chk("abort_x0", ObjectStartX[0], 0);
    chk("abort_x3", ObjectStartX[3], 48);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (update_done) nd++;
      @(negedge CLK);
    end
    chk("abort_no_done", nd, 0);
    chk("abort_no_ovr", frame_overrun, 0);

    // Asynchronous reset in the middle of a sweep.
    frame(2, nb, nd);
    @(negedge CLK); startOfFrame = 1'b1;
    @(negedge CLK); startOfFrame = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RESETn = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_x0", ObjectStartX[0], 0);
    chk("async_x14", ObjectStartX[14], 644);
    @(negedge CLK); RESETn = 1'b1;

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      startOfFrame = ($urandom_range(0, 14) == 0);
      enable       = ($urandom_range(0, 7) != 0);
      restart      = ($urandom_range(0, 149) == 0);
      level        = 3'($urandom_range(0, 6));
    end
    @(negedge CLK);
    startOfFrame = 1'b0; restart = 1'b0;
    repeat (20) @(negedge CLK);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
